loop_buffer_rd_sched: RTL

- Read-side scheduler for the block-based loop buffer, which tracks occupancy via `free_size`.
- Detects when at least one complete block is resident in the buffer.
- Sweeps the intra-block read address `0..BLK_LEN-1` `REPEAT` times, so each block is replayed once per beam/layer pass.
- Releases the block with a one-cycle `rd_rdy` pulse and emits `sop`/`eop`/`vld` markers aligned to the RAM read latency.
- Sits between the loop buffer and the dimension-reduction datapath.

---
 rtl/loop_buffer_rd_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/loop_buffer_rd_sched.sv
// Read-side scheduler for the block-based loop buffer: replays each resident
// block REPEAT times and emits markers aligned to the RAM read latency.
module loop_buffer_rd_sched #(
  parameter int RADDR_WIDTH  = 8,
  parameter int BLK_LEN      = 256,
  parameter int LOOP_WIDTH   = 9,
  parameter int WADDR_WIDTH  = 8,
  parameter int READ_LATENCY = 3,
  parameter int REPEAT       = 1,
  parameter int RPT_WIDTH    = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int INFO_WIDTH   = 256
) (
  input  logic                               clk,
  input  logic                               syn_rst,
  input  logic                               sch_en,
  input  logic [LOOP_WIDTH-WADDR_WIDTH:0]    free_size,
  input  logic [INFO_WIDTH-1:0]              rd_info,
  output logic [RADDR_WIDTH-1:0]             rd_addr,
  output logic                               rd_rdy,
  output logic                               out_vld,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic [RPT_WIDTH-1:0]               out_rpt,
  output logic [INFO_WIDTH-1:0]              out_info,
  output logic                               busy,
  output logic [15:0]                        blk_cnt
);

  localparam int FS_W = LOOP_WIDTH - WADDR_WIDTH + 1;
  localparam int NBLK = 2 ** (LOOP_WIDTH - WADDR_WIDTH);
  localparam logic [FS_W-1:0]        FREE_EMPTY = FS_W'(NBLK);
  localparam logic [RADDR_WIDTH-1:0] ADDR_LAST  = RADDR_WIDTH'(BLK_LEN - 1);
  localparam logic [RPT_WIDTH-1:0]   RPT_LAST   = RPT_WIDTH'(REPEAT - 1);
  localparam logic [7:0]             GAP_LOAD   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [RADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RPT_WIDTH-1:0]   rpt_q, rpt_d;
  logic [7:0]             gap_q, gap_d;
  logic [INFO_WIDTH-1:0]  info_q, info_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   vld_p [READ_LATENCY];
  logic                   sop_p [READ_LATENCY];
  logic                   eop_p [READ_LATENCY];
  logic [RPT_WIDTH-1:0]   rpt_p [READ_LATENCY];

  logic issue, pass_end, blk_end, avail;

  assign avail    = (free_size != FREE_EMPTY);
  assign issue    = (state_q == ST_READ);
  assign pass_end = issue && (addr_q == ADDR_LAST);
  assign blk_end  = pass_end && (rpt_q == RPT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rpt_d   = rpt_q;
    gap_d   = gap_q;
    info_d  = info_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sch_en && avail) begin
          state_d = ST_READ;
          addr_d  = '0;
          rpt_d   = '0;
          info_d  = rd_info;
        end
      end
      ST_READ: begin
        if (blk_end) begin
          // Final pass done: release the block in this same issue cycle.
          addr_d  = '0;
          rpt_d   = '0;
          cnt_d   = cnt_q + 16'd1;
          gap_d   = GAP_LOAD;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else if (pass_end) begin
          addr_d = '0;
          rpt_d  = rpt_q + RPT_WIDTH'(1);
        end else begin
          addr_d = addr_q + RADDR_WIDTH'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rpt_q   <= '0;
      gap_q   <= '0;
      info_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rpt_q   <= rpt_d;
      gap_q   <= gap_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
    end
  end

  // Marker pipeline: stage 0 captures the issue cycle, last stage meets rd_data.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        sop_p[i] <= 1'b0;
        eop_p[i] <= 1'b0;
        rpt_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= issue;
      sop_p[0] <= issue && (addr_q == '0);
      eop_p[0] <= pass_end;
      rpt_p[0] <= issue ? rpt_q : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        sop_p[i] <= sop_p[i-1];
        eop_p[i] <= eop_p[i-1];
        rpt_p[i] <= rpt_p[i-1];
      end
    end
  end

  assign rd_addr  = addr_q;
  assign rd_rdy   = blk_end;
  assign out_vld  = vld_p[READ_LATENCY-1];
  assign out_sop  = sop_p[READ_LATENCY-1];
  assign out_eop  = eop_p[READ_LATENCY-1];
  assign out_rpt  = rpt_p[READ_LATENCY-1];
  assign out_info = info_q;
  assign busy     = (state_q != ST_IDLE);
  assign blk_cnt  = cnt_q;

endmodule
